// File: rtl/adsr_engine.sv
// adsr_engine: time-multiplexed multi-voice ADSR envelope generator.
// Each i_tick sweeps all voices, one per clock, and emits a registered
// (voice, volume, state) sample per voice for the downstream mixer.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_tick            one-cycle strobe that starts a sweep (ignored while busy)
//   i_note_on/off     note events for voice i_voice (note-on wins if both)
//   i_velocity        velocity latched with note-on
//   sustain_value     global sustain level
//   attack/decay/release_rate  per-tick volume step sizes
//   o_valid, o_voice  output sample strobe and its voice index
//   o_volume, o_state updated envelope volume and state (written back)
//   o_busy            sweep in progress
module adsr_engine #(
    parameter int NUM_VOICES = 8,
    parameter int VOL_W      = 18,
    parameter int RATE_W     = 7,
    localparam int VIDX_W    = $clog2(NUM_VOICES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_tick,
    input  logic              i_note_on,
    input  logic              i_note_off,
    input  logic [VIDX_W-1:0] i_voice,
    input  logic [6:0]        i_velocity,
    input  logic [6:0]        sustain_value,
    input  logic [RATE_W-1:0] attack_rate,
    input  logic [RATE_W-1:0] decay_rate,
    input  logic [RATE_W-1:0] release_rate,
    output logic              o_valid,
    output logic [VIDX_W-1:0] o_voice,
    output logic [VOL_W-1:0]  o_volume,
    output logic [2:0]        o_state,
    output logic              o_busy
);

    localparam logic [2:0] S_BLANK   = 3'd0;
    localparam logic [2:0] S_ATTACK  = 3'd1;
    localparam logic [2:0] S_DECAY   = 3'd2;
    localparam logic [2:0] S_SUSTAIN = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;

    localparam int LVL_SH = VOL_W - 8;
    localparam logic [VIDX_W:0] CNT_END = (VIDX_W + 1)'(NUM_VOICES);
    localparam logic [VIDX_W:0] CNT_ONE = (VIDX_W + 1)'(1);

    logic [2:0]            state_q [NUM_VOICES];
    logic [VOL_W-1:0]      vol_q   [NUM_VOICES];
    logic [6:0]            vel_q   [NUM_VOICES];
    logic [NUM_VOICES-1:0] pon_q, pon_d;
    logic [NUM_VOICES-1:0] poff_q, poff_d;

    logic                  busy_q;
    logic [VIDX_W:0]       cnt_q;

    logic                  valid_q;
    logic [VIDX_W-1:0]     voice_q;
    logic [VOL_W-1:0]      ovol_q;
    logic [2:0]            ost_q;

    logic                  srv_start, srv_run, srv_en;
    logic [VIDX_W-1:0]     srv_idx;
    logic [2:0]            cur_st, nst;
    logic [VOL_W-1:0]      cur_vol, nvol;
    logic [VOL_W-1:0]      vel_lvl, sus_lvl;
    logic [VOL_W-1:0]      ar, dr, rr;
    logic [VOL_W:0]        sum_a, dec_thr;
    logic                  clr_on, clr_off;

    // Voice 0 is serviced on the edge that accepts the tick; the counter
    // then walks the remaining voices while busy.
    assign srv_start = i_tick && !busy_q;
    assign srv_run   = busy_q && (cnt_q != CNT_END);
    assign srv_en    = srv_start || srv_run;
    assign srv_idx   = srv_start ? '0 : cnt_q[VIDX_W-1:0];

    assign cur_st  = state_q[srv_idx];
    assign cur_vol = vol_q[srv_idx];
    assign vel_lvl = {1'b0, vel_q[srv_idx], {LVL_SH{1'b0}}};
    assign sus_lvl = {1'b0, sustain_value, {LVL_SH{1'b0}}};
    assign ar      = VOL_W'(attack_rate);
    assign dr      = VOL_W'(decay_rate);
    assign rr      = VOL_W'(release_rate);

    // One extra bit so neither sum can wrap.
    assign sum_a   = {1'b0, cur_vol} + {1'b0, ar};
    assign dec_thr = {1'b0, sus_lvl} + {1'b0, dr};

    always_comb begin
        nst     = cur_st;
        nvol    = cur_vol;
        clr_on  = 1'b0;
        clr_off = 1'b0;
        if (pon_q[srv_idx]) begin
            // Retrigger keeps the current volume to avoid a click.
            nst    = S_ATTACK;
            clr_on = 1'b1;
        end else if (poff_q[srv_idx]) begin
            clr_off = 1'b1;
            if (cur_st == S_ATTACK || cur_st == S_DECAY ||
                cur_st == S_SUSTAIN) begin
                nst = S_RELEASE;
            end
        end else begin
            case (cur_st)
                S_ATTACK: begin
                    if (ar != '0) begin
                        if (sum_a >= {1'b0, vel_lvl}) begin
                            nvol = vel_lvl;
                            nst  = S_DECAY;
                        end else begin
                            nvol = sum_a[VOL_W-1:0];
                        end
                    end
                end
                S_DECAY: begin
                    if ({1'b0, cur_vol} <= dec_thr) begin
                        nvol = sus_lvl;
                        nst  = S_SUSTAIN;
                    end else begin
                        nvol = cur_vol - dr;
                    end
                end
                S_SUSTAIN: nvol = sus_lvl;
                S_RELEASE: begin
                    if (rr != '0) begin
                        if (cur_vol <= rr) begin
                            nvol = '0;
                            nst  = S_BLANK;
                        end else begin
                            nvol = cur_vol - rr;
                        end
                    end
                end
                default: begin
                    nvol = '0;
                    nst  = S_BLANK;
                end
            endcase
        end
    end

    // Consume-clear is applied first so a same-cycle event wins.
    always_comb begin
        pon_d  = pon_q;
        poff_d = poff_q;
        if (srv_en && clr_on)  pon_d[srv_idx]  = 1'b0;
        if (srv_en && clr_off) poff_d[srv_idx] = 1'b0;
        if (i_note_on) begin
            pon_d[i_voice]  = 1'b1;
            poff_d[i_voice] = 1'b0;
        end else if (i_note_off) begin
            poff_d[i_voice] = 1'b1;
            pon_d[i_voice]  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                state_q[v] <= S_BLANK;
                vol_q[v]   <= '0;
                vel_q[v]   <= '0;
            end
            pon_q   <= '0;
            poff_q  <= '0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            voice_q <= '0;
            ovol_q  <= '0;
            ost_q   <= S_BLANK;
        end else begin
            if (srv_en) begin
                state_q[srv_idx] <= nst;
                vol_q[srv_idx]   <= nvol;
                voice_q          <= srv_idx;
                ovol_q           <= nvol;
                ost_q            <= nst;
            end
            if (i_note_on) vel_q[i_voice] <= i_velocity;
            pon_q   <= pon_d;
            poff_q  <= poff_d;
            valid_q <= srv_en;
            if (srv_start) begin
                busy_q <= 1'b1;
                cnt_q  <= CNT_ONE;
            end else if (srv_run) begin
                cnt_q <= cnt_q + CNT_ONE;
            end else begin
                busy_q <= 1'b0;
                cnt_q  <= '0;
            end
        end
    end

    assign o_valid  = valid_q;
    assign o_voice  = voice_q;
    assign o_volume = ovol_q;
    assign o_state  = ost_q;
    assign o_busy   = busy_q;

endmodule
